// File: rtl/instr_fetch.sv
// instr_fetch: instruction fetch unit for the X9 core.
// Owns the fetch PC and issues one read per cycle at most to a synchronous
// instruction memory. Returned words, tagged with their addresses, go into a
// small FIFO whose head is offered to the decoder with a valid/ready handshake.
// Start and taken branches redirect fetch: the FIFO is flushed, any return
// still in flight is dropped, and the redirect target is requested on the
// same edge.
// Optional build macro: INSTR_FETCH_BRANCH_COUNT_EN adds a saturating
// taken-branch counter on BranchCount. Without it, BranchCount is tied to 0.
module instr_fetch #(
  parameter int IW        = 9,
  parameter int PCW       = 10,
  parameter int BUF_DEPTH = 2,
  parameter int PROG_LEN  = 1024
) (
  input  logic           Clk,
  input  logic           Reset,
  input  logic           Start,
  output logic           ImemReq,
  output logic [PCW-1:0] ImemAddr,
  input  logic [IW-1:0]  ImemData,
  output logic [IW-1:0]  Instr,
  output logic [PCW-1:0] InstrPC,
  output logic           InstrValid,
  input  logic           InstrReady,
  input  logic           BranchTaken,
  input  logic [PCW-1:0] Target,
  output logic           Done,
  output logic [15:0]    BranchCount
);

  localparam int AW = $clog2(BUF_DEPTH);
  // The fetch PC is one bit wider than the address so it can reach PROG_LEN.
  localparam logic [PCW:0]   LP_PROG_LEN = (PCW+1)'(PROG_LEN);
  localparam logic [PCW-1:0] LP_LAST_PC  = PCW'(PROG_LEN - 1);
  localparam logic [AW:0]    LP_DEPTH    = (AW+1)'(BUF_DEPTH);
  localparam logic [PCW:0]   LP_PC_ONE   = (PCW+1)'(1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t r_state;
  state_t w_next_state;

  logic [PCW:0]   r_fpc;
  logic           r_imem_req;
  logic [PCW-1:0] r_imem_addr;
  logic           r_pend;
  logic [PCW-1:0] r_pend_pc;
  logic [AW-1:0]  r_wr_ptr;
  logic [AW-1:0]  r_rd_ptr;
  logic [AW:0]    r_count;
  logic [IW-1:0]  r_buf_instr [BUF_DEPTH];
  logic [PCW-1:0] r_buf_pc    [BUF_DEPTH];

  logic           w_head_valid;
  logic           w_pop;
  logic           w_push;
  logic           w_branch;
  logic           w_redirect;
  logic           w_flush;
  logic           w_last_accept;
  logic           w_issue;
  logic [PCW:0]   w_redir_pc;
  logic [PCW:0]   w_fetch_pc;
  logic [AW:0]    w_occ_next;
  logic [AW:0]    w_outstanding;

  // Handshake and redirect decode
  assign w_head_valid  = (r_state == S_RUN) && (r_count != '0);
  assign w_pop         = w_head_valid && InstrReady;
  assign w_branch      = (r_state == S_RUN) && BranchTaken;
  assign w_redirect    = Start || w_branch;
  assign w_last_accept = w_pop && (r_buf_pc[r_rd_ptr] == LP_LAST_PC) &&
                         !BranchTaken && !Start;

  // Start wins over a simultaneous branch and always targets address 0.
  assign w_redir_pc = Start ? '0 : {1'b0, Target};
  assign w_fetch_pc = w_redirect ? w_redir_pc : r_fpc;

  // Anything that leaves or re-enters RUN discards buffered and in-flight words.
  assign w_flush = w_redirect || (w_next_state != S_RUN);
  assign w_push  = r_pend && !w_flush;

  // Occupancy after this edge plus the return still due must leave room for one
  // more word, so every return is guaranteed a free slot.
  assign w_occ_next    = w_flush ? '0 : (r_count + (AW+1)'(w_push) - (AW+1)'(w_pop));
  assign w_outstanding = (AW+1)'(r_imem_req && !w_flush);
  assign w_issue       = (w_next_state == S_RUN) &&
                         ((w_occ_next + w_outstanding) < LP_DEPTH) &&
                         (w_fetch_pc < LP_PROG_LEN);

  // FSM state register
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // FSM next-state: redirects, out-of-range branches and program end
  always_comb begin
    w_next_state = r_state;
    unique case (r_state)
      S_IDLE: begin
        if (Start) w_next_state = S_RUN;
      end
      S_RUN: begin
        if (Start) begin
          w_next_state = S_RUN;
        end else if (BranchTaken) begin
          w_next_state = ({1'b0, Target} >= LP_PROG_LEN) ? S_DONE : S_RUN;
        end else if (w_last_accept) begin
          w_next_state = S_DONE;
        end
      end
      S_DONE: begin
        if (Start) w_next_state = S_RUN;
      end
      default: w_next_state = S_IDLE;
    endcase
  end

  // FSM outputs: head of the buffer is shown only while running and non-empty
  always_comb begin
    InstrValid = w_head_valid;
    Instr      = '0;
    InstrPC    = '0;
    Done       = (r_state == S_DONE);
    if (w_head_valid) begin
      Instr   = r_buf_instr[r_rd_ptr];
      InstrPC = r_buf_pc[r_rd_ptr];
    end
  end

  assign ImemReq  = r_imem_req;
  assign ImemAddr = r_imem_addr;

  // Fetch PC, request issue, in-flight tracking and FIFO pointers
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      r_fpc       <= '0;
      r_imem_req  <= 1'b0;
      r_imem_addr <= '0;
      r_pend      <= 1'b0;
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_count     <= '0;
    end else begin
      r_fpc      <= w_issue ? (w_fetch_pc + LP_PC_ONE) : w_fetch_pc;
      r_imem_req <= w_issue;
      if (w_issue) begin
        r_imem_addr <= w_fetch_pc[PCW-1:0];
      end
      r_pend  <= r_imem_req && !w_flush;
      r_count <= w_occ_next;
      if (w_flush) begin
        r_wr_ptr <= '0;
        r_rd_ptr <= '0;
      end else begin
        if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
        if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      end
    end
  end

  // Capture returning memory data with its address at the buffer tail
  always_ff @(posedge Clk) begin
    r_pend_pc <= r_imem_addr;
    if (w_push) begin
      r_buf_instr[r_wr_ptr] <= ImemData;
      r_buf_pc[r_wr_ptr]    <= r_pend_pc;
    end
  end

`ifdef INSTR_FETCH_BRANCH_COUNT_EN
  logic [15:0] r_branch_cnt;

  // Saturating count of branches sampled in RUN; Start restarts the count
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      r_branch_cnt <= '0;
    end else if (Start) begin
      r_branch_cnt <= '0;
    end else if (w_branch && (r_branch_cnt != 16'hFFFF)) begin
      r_branch_cnt <= r_branch_cnt + 16'd1;
    end
  end

  assign BranchCount = r_branch_cnt;
`else
  assign BranchCount = '0;
`endif

endmodule
